// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller for the 5-stage MIPS core: stage freeze/flush
// sequencing, EX forwarding selects, and the multi-cycle SRAM wait-state FSM.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 6,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic       id_uses_src2,
  input  logic [4:0] ex_src1,
  input  logic [4:0] ex_src2,
  input  logic [4:0] ex_dest,
  input  logic       ex_wb_en,
  input  logic       ex_mem_r_en,
  input  logic [4:0] mem_dest,
  input  logic       mem_wb_en,
  input  logic       mem_req,
  input  logic [4:0] wb_dest,
  input  logic       wb_wb_en,
  input  logic       br_taken,
  output logic       if_freeze,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       pipe_freeze,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       mem_busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam bit         MULTI_CYCLE = (MEM_WAIT > 1);
  localparam logic [3:0] WAIT_INIT   = (MEM_WAIT > 1) ? 4'(MEM_WAIT - 2) : 4'd0;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       freeze;
  logic       ex_hits_id, mem_hits_id, data_hazard;

  function automatic logic [1:0] pick_src(input logic [4:0] src,
                                          input logic [4:0] m_dest, input logic m_en,
                                          input logic [4:0] w_dest, input logic w_en);
    if (src != '0 && m_en && m_dest == src)      return 2'b01;
    else if (src != '0 && w_en && w_dest == src) return 2'b10;
    else                                         return 2'b00;
  endfunction

  // Register $0 is hardwired zero, so a dest of 0 never matches a reader.
  assign ex_hits_id  = (ex_dest != '0) &&
                       ((ex_dest == id_src1) || (id_uses_src2 && ex_dest == id_src2));
  assign mem_hits_id = (mem_dest != '0) &&
                       ((mem_dest == id_src1) || (id_uses_src2 && mem_dest == id_src2));
  assign data_hazard = FWD_EN ? (ex_mem_r_en && ex_hits_id)
                              : ((ex_wb_en && ex_hits_id) || (mem_wb_en && mem_hits_id));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    freeze     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && MULTI_CYCLE) begin
          freeze     = 1'b1;
          cnt_next   = WAIT_INIT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // cnt==0 is the release cycle: the access finishes and the pipe advances.
        if (cnt != '0) begin
          freeze   = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A frozen pipe masks branches and hazards; they are re-evaluated on release.
  always_comb begin
    if_freeze   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    fwd_a_sel   = 2'b00;
    fwd_b_sel   = 2'b00;
    mem_busy    = 1'b0;
    if (!rst) begin
      pipe_freeze = freeze;
      mem_busy    = (state == WAIT);
      if (FWD_EN) begin
        fwd_a_sel = pick_src(ex_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
        fwd_b_sel = pick_src(ex_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
      end
      if (freeze) begin
        if_freeze = 1'b1;
      end else if (br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (data_hazard) begin
        if_freeze   = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checks of pipe_hazard_ctrl against a cycle-age
// reference model; one forwarding/6-cycle instance and one stall-only/1-cycle one.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       if_freeze;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       pipe_freeze;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, ex_src1, ex_src2, ex_dest, mem_dest, wb_dest;
  logic       id_uses_src2, ex_wb_en, ex_mem_r_en, mem_wb_en, mem_req, wb_wb_en, br_taken;

  exp_t got_f, got_n, last_got;
  int   total = 0;
  int   bad   = 0;
  int   age_f = 1;
  int   age_n = 1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_WAIT(6), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .br_taken(br_taken),
    .if_freeze(got_f.if_freeze), .if_id_flush(got_f.if_id_flush),
    .id_ex_flush(got_f.id_ex_flush), .pipe_freeze(got_f.pipe_freeze),
    .fwd_a_sel(got_f.fa), .fwd_b_sel(got_f.fb), .mem_busy(got_f.busy)
  );

  pipe_hazard_ctrl #(.MEM_WAIT(1), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .br_taken(br_taken),
    .if_freeze(got_n.if_freeze), .if_id_flush(got_n.if_id_flush),
    .id_ex_flush(got_n.id_ex_flush), .pipe_freeze(got_n.pipe_freeze),
    .fwd_a_sel(got_n.fa), .fwd_b_sel(got_n.fb), .mem_busy(got_n.busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] srcSel(input logic [4:0] r);
    if (r != 0 && mem_wb_en && mem_dest == r) return 2'b01;
    if (r != 0 && wb_wb_en && wb_dest == r)   return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit readsId(input logic [4:0] d);
    return d != 0 && (d == id_src1 || (id_uses_src2 && d == id_src2));
  endfunction

  // age = how many cycles the access at the head of MEM has occupied it so far
  function automatic exp_t model(input bit fwd, input int mem_wait, input int age);
    exp_t e = '0;
    bit   hz;
    if (rst) return e;
    e.pipe_freeze = (age == 1) ? (mem_req && mem_wait > 1) : (age < mem_wait);
    e.busy        = (age > 1);
    if (fwd) begin
      e.fa = srcSel(ex_src1);
      e.fb = srcSel(ex_src2);
    end
    hz = fwd ? (ex_mem_r_en && readsId(ex_dest))
             : ((ex_wb_en && readsId(ex_dest)) || (mem_wb_en && readsId(mem_dest)));
    if (e.pipe_freeze) e.if_freeze = 1'b1;
    else if (br_taken) begin
      e.if_id_flush = 1'b1;
      e.id_ex_flush = 1'b1;
    end else if (hz) begin
      e.if_freeze   = 1'b1;
      e.id_ex_flush = 1'b1;
    end
    return e;
  endfunction

  task automatic clearInputs();
    {id_src1, id_src2, ex_src1, ex_src2, ex_dest, mem_dest, wb_dest} = '0;
    {id_uses_src2, ex_wb_en, ex_mem_r_en, mem_wb_en, mem_req, wb_wb_en, br_taken} = '0;
  endtask

  task automatic applyStimulus();
    id_src1      = 5'($urandom_range(0, 3));
    id_src2      = 5'($urandom_range(0, 3));
    ex_src1      = 5'($urandom_range(0, 3));
    ex_src2      = 5'($urandom_range(0, 3));
    ex_dest      = 5'($urandom_range(0, 3));
    mem_dest     = 5'($urandom_range(0, 3));
    wb_dest      = 5'($urandom_range(0, 3));
    id_uses_src2 = 1'($urandom_range(0, 1));
    ex_wb_en     = 1'($urandom_range(0, 1));
    ex_mem_r_en  = 1'($urandom_range(0, 1));
    mem_wb_en    = 1'($urandom_range(0, 1));
    wb_wb_en     = 1'($urandom_range(0, 1));
    mem_req      = ($urandom_range(0, 3) == 0);
    br_taken     = ($urandom_range(0, 7) == 0);
    rst          = ($urandom_range(0, 39) == 0);
  endtask

  // Samples both instances at the falling edge, then advances the model ages.
  task automatic runCycle(input string tag);
    exp_t ef, en;
    @(negedge clk);
    ef = model(1'b1, 6, age_f);
    en = model(1'b0, 1, age_n);
    last_got = got_f;
    checkOutput({tag, "/fwd"}, 32'(got_f), 32'(ef));
    checkOutput({tag, "/nofwd"}, 32'(got_n), 32'(en));
    @(posedge clk);
    age_f = rst ? 1 : (ef.pipe_freeze ? age_f + 1 : 1);
    age_n = rst ? 1 : (en.pipe_freeze ? age_n + 1 : 1);
    #1;
  endtask

  initial begin
    logic [11:0] fpat, bpat;
    logic [5:0]  rpat;
    fpat = 12'b111110111110;
    bpat = 12'b011111011111;
    rpat = 6'b111110;

    clearInputs();
    rst = 1'b1;
    runCycle("reset");
    checkOutput("reset_all_zero", 32'(last_got), 32'd0);
    runCycle("reset");
    rst = 1'b0;

    ex_src1 = 5; mem_dest = 5; mem_wb_en = 1; wb_dest = 5; wb_wb_en = 1;
    runCycle("fwd");
    checkOutput("fwd_a_exmem", 32'(last_got.fa), 32'd1);
    mem_wb_en = 0;
    runCycle("fwd");
    checkOutput("fwd_a_wb", 32'(last_got.fa), 32'd2);
    clearInputs();
    runCycle("fwd");
    checkOutput("fwd_a_r0", 32'(last_got.fa), 32'd0);

    ex_mem_r_en = 1; ex_dest = 8; id_src2 = 8; id_uses_src2 = 1;
    runCycle("loaduse");
    checkOutput("loaduse_freeze", 32'(last_got.if_freeze), 32'd1);
    checkOutput("loaduse_bubble", 32'(last_got.id_ex_flush), 32'd1);
    ex_mem_r_en = 0; ex_dest = 0; mem_dest = 8; mem_wb_en = 1;
    runCycle("loaduse_after");
    checkOutput("loaduse_one_bubble", 32'(last_got.if_freeze), 32'd0);
    clearInputs();
    ex_mem_r_en = 1; ex_dest = 8; id_src2 = 8; id_uses_src2 = 0;
    runCycle("no_src2");
    checkOutput("no_src2_stall", 32'(last_got.if_freeze), 32'd0);

    clearInputs();
    ex_mem_r_en = 1; ex_dest = 8; id_src1 = 8; br_taken = 1;
    runCycle("branch");
    checkOutput("br_if_id_flush", 32'(last_got.if_id_flush), 32'd1);
    checkOutput("br_id_ex_flush", 32'(last_got.id_ex_flush), 32'd1);
    checkOutput("br_no_freeze", 32'(last_got.if_freeze), 32'd0);

    clearInputs();
    mem_req = 1;
    for (int i = 0; i < 12; i++) begin
      runCycle("b2b");
      checkOutput($sformatf("b2b_freeze%0d", i + 1), 32'(last_got.pipe_freeze), 32'(fpat[11 - i]));
      checkOutput($sformatf("b2b_busy%0d", i + 1), 32'(last_got.busy), 32'(bpat[11 - i]));
    end

    br_taken = 1;
    for (int i = 0; i < 6; i++) begin
      runCycle("br_frozen");
      checkOutput($sformatf("br_frozen_flush%0d", i + 1), 32'(last_got.if_id_flush),
                  32'(i == 5));
    end
    clearInputs();
    runCycle("idle");

    mem_req = 1;
    for (int i = 0; i < 3; i++) runCycle("pre_abort");
    rst = 1;
    runCycle("abort");
    checkOutput("abort_zero", 32'(last_got), 32'd0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      runCycle("restart");
      checkOutput($sformatf("restart_freeze%0d", i + 1), 32'(last_got.pipe_freeze), 32'(rpat[5 - i]));
      if (i == 0) checkOutput("restart_idle", 32'(last_got.busy), 32'd0);
    end

    for (int i = 0; i < 600; i++) begin
      applyStimulus();
      runCycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core.
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB registers by driving their freeze and flush inputs.
- Selects EX-stage forwarding paths.
- Runs a wait-state FSM that holds the whole pipeline while a multi-cycle SRAM access sits in MEM.
- Sits beside the datapath; all stage registers take their freeze/flush from this block.

Parameters:
MEM_WAIT, 6, total cycles a load/store occupies MEM (legal 1..16)
FWD_EN, 1, 1 = forwarding enabled; 0 = resolve all RAW hazards by stalling

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
id_src1  in  5  rs of instruction in ID
id_src2  in  5  rt of instruction in ID
id_uses_src2  in  1  ID instruction reads rt (R-type, store, branch)
ex_src1  in  5  src1 held in ID/EX register
ex_src2  in  5  src2 held in ID/EX register
ex_dest  in  5  Dest in ID/EX
ex_wb_en  in  1  WB_EN in ID/EX
ex_mem_r_en  in  1  MEM_R_EN in ID/EX
mem_dest  in  5  Dest in EX/MEM
mem_wb_en  in  1  WB_EN in EX/MEM
mem_req  in  1  MEM_R_EN or MEM_W_EN in EX/MEM
wb_dest  in  5  Dest in MEM/WB
wb_wb_en  in  1  WB_EN in MEM/WB
br_taken  in  1  branch resolved taken in EX
if_freeze  out  1  hold PC and IF/ID register
if_id_flush  out  1  clear IF/ID register
id_ex_flush  out  1  insert bubble into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 EX/MEM result, 10 WB value
fwd_b_sel  out  2  EX operand B/store-data source, same encoding
mem_busy  out  1  wait FSM in WAIT state

Behaviour:
- Register $0 never creates a hazard or a forward (dest==0 ignored everywhere).
- Outputs are combinational from FSM state and inputs. While rst=1, all outputs are forced to 0.
- Forwarding (FWD_EN=1):
  - fwd_a_sel=01 if mem_wb_en && mem_dest==ex_src1.
  - Else fwd_a_sel=10 if wb_wb_en && wb_dest==ex_src1.
  - Else 00.
  - fwd_b_sel: same rules using ex_src2.
  - EX/MEM has priority over WB.
  - FWD_EN=0: both selects tie to 00.
- Load-use hazard (FWD_EN=1):
  - Condition: ex_mem_r_en && ex_dest!=0 && (ex_dest==id_src1 || (id_uses_src2 && ex_dest==id_src2)).
  - Response: if_freeze=1 and id_ex_flush=1 for that cycle. Exactly one bubble.
- FWD_EN=0 hazard:
  - Condition: any match of id sources against (ex_dest, ex_wb_en) or (mem_dest, mem_wb_en).
  - Response: same stall response, re-evaluated each cycle (up to 2 bubbles).
- Taken branch:
  - if_id_flush=1 and id_ex_flush=1; if_freeze=0 so the PC loads the target.
  - A taken branch overrides a simultaneous data stall.
- Memory wait FSM: states IDLE, WAIT; 4-bit counter cnt.
  - IDLE, mem_req=1, MEM_WAIT>1: pipe_freeze=1; cnt<=MEM_WAIT-2; go to WAIT.
  - IDLE, MEM_WAIT==1: never freezes.
  - WAIT, cnt!=0: pipe_freeze=1; cnt<=cnt-1.
  - WAIT, cnt==0: pipe_freeze=0 (release cycle, pipeline advances); go to IDLE.
  - Net effect: each access holds MEM for exactly MEM_WAIT cycles, of which MEM_WAIT-1 are frozen.
  - Back-to-back memory ops: the next op is seen in IDLE the cycle after release and restarts the sequence. No extra gap.
- While pipe_freeze=1:
  - if_freeze=1.
  - if_id_flush=0 and id_ex_flush=0.
  - br_taken and data hazards are ignored; the held EX/ID contents are re-evaluated on the release cycle.
- mem_busy=1 exactly when state==WAIT.
- Reset:
  - Synchronous reset returns the FSM to IDLE with cnt=0 at the next edge, including mid-WAIT.
  - An aborted access is not resumed.

Test Plan:
- FWD_EN=1; ex_src1=5, mem_dest=5/mem_wb_en=1, wb_dest=5/wb_wb_en=1 -> fwd_a_sel=01. Then mem_wb_en=0 -> 10. Then ex_src1=0 with all dests 0 -> 00.
- Load in EX (ex_mem_r_en=1, ex_dest=8); ID id_src2=8, id_uses_src2=1 -> one cycle of if_freeze=1, id_ex_flush=1. With id_uses_src2=0 -> no stall.
- br_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, if_freeze=0.
- MEM_WAIT=6; mem_req held high for two consecutive loads -> pipe_freeze pattern 1,1,1,1,1,0,1,1,1,1,1,0. mem_busy=1 on cycles 2-6 and 8-12.
- br_taken=1 during pipe_freeze -> no flush until the release cycle, where if_id_flush=id_ex_flush=1.
- rst pulsed at WAIT cnt=2 -> all outputs 0 during reset; IDLE afterward. mem_req still high restarts a full 6-cycle access.
